// File: rtl/apb_master_mux.sv
// APB requester driving NSLV address-decoded slaves from a valid/ready request port.
// One transfer in flight; completion reported on a single-cycle response strobe.
module apb_master_mux #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NSLV    = 4,
  parameter int unsigned SLV_AW  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   pclk,
  input  logic                   prst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [NSLV-1:0]        psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [ADDR_W-1:0]      paddr,
  output logic [DATA_W-1:0]      pwdata,
  input  logic [NSLV*DATA_W-1:0] prdata_s,
  input  logic [NSLV-1:0]        pready_s,
  input  logic [NSLV-1:0]        pslverr_s
);

  localparam int unsigned IDX_W  = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int unsigned HI_LSB = SLV_AW + IDX_W;
  localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NSLV-1:0]     psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [IDX_W-1:0]    req_idx;
  logic [NSLV-1:0]     req_sel;
  logic                dec_err;
  logic                sel_ready;
  logic                sel_err;
  logic [DATA_W-1:0]   sel_rdata;

  // Address decode of the incoming request; out-of-range index or stray high bits is an error.
  always_comb begin
    req_idx = req_addr[SLV_AW +: IDX_W];
    req_sel = '0;
    for (int k = 0; k < NSLV; k++) begin
      req_sel[k] = (req_idx == IDX_W'(k));
    end
    dec_err = ~(|req_sel) | (|(req_addr >> HI_LSB));
  end

  // Only the selected slave's handshake/data is observed.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (psel_q[k]) begin
        sel_ready = pready_s[k];
        sel_err   = pslverr_s[k];
        sel_rdata = prdata_s[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          pwdata_d = req_wdata;
          pwrite_d = req_write;
          if (dec_err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            psel_d    = req_sel;
            penable_d = 1'b0;
            cnt_d     = '0;
            state_d   = SETUP;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (sel_ready) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = sel_err;
          rsp_rdata_d = (!pwrite_q && !sel_err) ? sel_rdata : '0;
          psel_d      = '0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          psel_d      = '0;
          penable_d   = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        psel_d    = '0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_master_mux.md
Name: apb_master_mux

Overview:
- Parametrised APB requester and slave fabric: next generation of the single-master/single-slave APB subsystem.
- Accepts read/write requests on a valid/ready interface and runs APB SETUP/ACCESS phases.
- Decodes the address to one of NSLV slaves and honours per-slave PREADY wait states and PSLVERR.
- Aborts hung accesses with a timeout; returns read data and error status on a one-cycle response strobe.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- NSLV, 4, number of slaves; ≥1.
- SLV_AW, 8, byte-address bits per slave window. Slave index = paddr[SLV_AW +: max(1,clog2(NSLV))].
- TIMEOUT, 16, maximum ACCESS cycles without PREADY before abort; 0 disables the timeout.

Ports:
- pclk  in  1  clock, rising edge.
- prst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_rdata  out  DATA_W  read data (0 for writes and errors).
- rsp_err  out  1  slave error, decode error or timeout.
- psel  out  NSLV  one-hot slave select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata_s  in  NSLV*DATA_W  slave read data; slave k uses bits [k*DATA_W +: DATA_W].
- pready_s  in  NSLV  per-slave ready.
- pslverr_s  in  NSLV  per-slave error.

Behaviour:
- Reset (prst low, asynchronous) forces:
  - state IDLE;
  - psel, penable, pwrite, paddr, pwdata = 0;
  - rsp_valid, rsp_rdata, rsp_err = 0;
  - timeout counter = 0.
- Reset mid-transfer drops psel/penable immediately; no response is issued for the aborted request.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready=1 (combinational from state).
  - On req_valid: latch addr, wdata, write into paddr/pwdata/pwrite and decode.
  - Decode error when the index ≥ NSLV or any address bit above the index field is 1. Go directly to the IDLE response path: next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0, no psel asserted.
  - Otherwise set psel[idx]=1, penable=0 and go to SETUP.
- SETUP: exactly one cycle; penable←1, go to ACCESS. req_ready=0.
- ACCESS:
  - Sample pready_s[idx] each cycle.
  - When high: capture rsp_rdata = prdata_s[idx] (read) or 0 (write), rsp_err = pslverr_s[idx]. Also rsp_rdata=0 if pslverr on a read.
  - Then pulse rsp_valid next cycle, drop psel/penable and return to IDLE.
- Timeout:
  - The counter increments each ACCESS cycle with pready low.
  - When the count reaches TIMEOUT: abort, drop psel/penable, rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - Counter clears on entry to SETUP.
- Response timing: rsp_valid is registered and asserted in the first IDLE cycle after completion. A new request may be accepted in that same cycle (back-to-back).
- Zero-wait throughput: one transfer per 3 cycles (accept, SETUP, ACCESS); response is at accept+3.
- paddr/pwrite/pwdata/psel stay stable from SETUP through the last ACCESS cycle.
- pready_s/pslverr_s of non-selected slaves are ignored.
- rsp_rdata/rsp_err hold until the next response. rsp_valid is high for exactly 1 cycle per accepted request.
- No request is ever dropped: every req_valid&req_ready handshake yields exactly one rsp_valid (unless reset intervenes).

Test Plan:
- Write 0xDEADBEEF to addr 0x0000_0104, slave1 pready=1 immediately → psel=4'b0010 for 2 cycles, penable only in the 2nd; rsp_valid at accept+3, rsp_err=0, rsp_rdata=0.
- Read addr 0x0000_0308, slave3 holds pready low 3 cycles then returns 0x1234_5678 → ACCESS lasts 4 cycles; rsp_rdata=0x12345678 at accept+6; paddr stable throughout.
- Read addr 0x0000_0400 (index 4 ≥ NSLV) → no psel bit set; rsp_valid next cycle with rsp_err=1, rsp_rdata=0.
- Slave0 never asserts pready, TIMEOUT=16 → abort after 16 ACCESS cycles; psel drops; rsp_err=1; next request accepted normally.
- Slave2 returns pslverr=1 with pready on a read of 0x0000_0200 → rsp_err=1, rsp_rdata=0. Back-to-back write then read with req_valid held high → second accept coincides with first rsp_valid.
- Assert prst low during ACCESS of a wait-stated read → psel, penable and rsp_valid are 0 asynchronously; after release, state is IDLE with req_ready=1 and no spurious rsp_valid.
